hilo_muldiv: RTL and testbench
==============================

HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 The block SHALL have a single clock `clk`, and `reset` SHALL be asynchronous and active-low.
REQ-002 The block SHALL provide the following ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  launch operation; sampled only in IDLE.
- Mul  in  1  operation select: multiply.
- Div  in  1  operation select: divide.
- Unsigned  in  1  1 = unsigned operands, 0 = two's-complement operands.
- op_a  in  32  multiplicand or dividend (rs value).
- op_b  in  32  multiplier or divisor (rt value).
- WriteHi  in  1  MTHI strobe.
- WriteLo  in  1  MTLO strobe.
- write_data  in  32  data for MTHI/MTLO.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when results are committed to HI/LO.
- div_by_zero  out  1  one-cycle pulse, coincident with done, for a divide with op_b = 0.

Function
REQ-003 The state machine SHALL have the states IDLE, CALC and SIGN; the reset state SHALL be IDLE.
REQ-004 In IDLE, start=1 with exactly one of Mul/Div high SHALL latch op_a, op_b, the operation and Unsigned at that edge (edge 0), and SHALL move to CALC with the iteration counter at 0.
REQ-005 In IDLE, start=1 with Mul=Div=0 or Mul=Div=1 SHALL be ignored: the state stays IDLE and no done pulse is produced.
REQ-006 For signed operations, the block SHALL latch the magnitudes |op_a| and |op_b| and retain the operand signs for SIGN.
REQ-007 CALC SHALL perform one iteration per cycle for 32 cycles (counter 0..31) and then move to SIGN.
- Multiply: radix-2 shift-add, producing a 64-bit product.
- Divide: restoring shift-subtract, producing a 32-bit quotient and a 32-bit remainder.
REQ-008 SIGN SHALL apply the sign correction, commit the results to HI/LO and return to IDLE at edge 33.
- Sign correction applies only when Unsigned=0.
- Product: negated when the operand signs differ.
- Quotient: negated when the operand signs differ.
- Remainder: takes the sign of the dividend.
REQ-009 Result placement SHALL be as follows.
- Multiply: hi = product[63:32], lo = product[31:0].
- Divide: lo = quotient, hi = remainder.
REQ-010 busy SHALL be 1 in the cycles following edge 0 up to edge 33, and 0 otherwise.
REQ-011 done SHALL be registered, 1 for exactly the one cycle following edge 33, with hi/lo already holding the new values in that cycle.
REQ-012 A divide with latched op_b=0 SHALL leave hi/lo unchanged while still producing done and div_by_zero pulses at the normal edge-33 timing.
REQ-013 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000 (wrap, no trap).
REQ-014 start asserted while busy=1 SHALL be ignored.
REQ-015 WriteHi/WriteLo handling SHALL depend on state.
- Ignored while busy=1.
- In IDLE, hi and/or lo are loaded from write_data at that edge.
- If start is also asserted at that edge, the write is applied and later overwritten by the operation result.
REQ-016 hi and lo SHALL change only on a result commit (REQ-008), an MTHI/MTLO write (REQ-015) or reset.

Reset
REQ-017 Asserting reset (low) at any time, including mid-operation, SHALL immediately force the following, with no completion pulse for an aborted operation:
- state = IDLE
- hi = 0x00000000
- lo = 0x00000000
- busy = 0, done = 0, div_by_zero = 0
- counter = 0
REQ-018 After reset is deasserted, the first start SHALL be accepted at the next rising edge.

Configuration
REQ-019 The macro HILO_FAST_MUL_EN SHALL select the multiply implementation.
- Defined: multiply uses a single-cycle 64-bit combinational multiplier. The path goes IDLE to SIGN, skipping CALC. Results are committed at edge 1, done is 1 in the cycle after edge 1, and busy is 1 only between edge 0 and edge 1.
- Undefined: multiply takes the 33-cycle iterative path of REQ-007.
- Divide timing is identical in both cases.

Verification
REQ-020 Unsigned multiply: Mul=1, Unsigned=1, op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, with done at edge 33 (edge 1 with HILO_FAST_MUL_EN).
REQ-021 Signed multiply: Mul=1, Unsigned=0, op_a=0xFFFFFFFD (-3), op_b=0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-022 Signed divide: Div=1, Unsigned=0, op_a=0xFFFFFFF9 (-7), op_b=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, with busy high for 33 cycles.
REQ-023 Divide by zero: preload hi=0x11111111 and lo=0x22222222 via WriteHi/WriteLo, then Div=1, Unsigned=1, op_a=100, op_b=0 -> hi/lo unchanged, and done and div_by_zero are each one-cycle pulses at edge 33.
REQ-024 Start while busy: a second start with different operands at edge 10 of a divide of 100/7 -> it is ignored, and the result is lo=14, hi=2.
REQ-025 Reset mid-operation: reset asserted at edge 15 of a multiply -> hi=lo=0, busy=0, no done pulse; a new divide of 9/3 started after release gives lo=3, hi=0.

Source files
------------

// File: rtl/hilo_muldiv_if.sv
// Operand, control and result bundle for the HI/LO multiply/divide unit.
interface hilo_muldiv_if;
  logic        start;
  logic        Mul;
  logic        Div;
  logic        Unsigned;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        WriteHi;
  logic        WriteLo;
  logic [31:0] write_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  modport master (
    output start, Mul, Div, Unsigned, op_a, op_b, WriteHi, WriteLo, write_data,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, Mul, Div, Unsigned, op_a, op_b, WriteHi, WriteLo, write_data,
    output hi, lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/hilo_muldiv.sv
// MIPS-style HI/LO multiply/divide unit: iterative shift-add multiply, restoring divide.
// Define HILO_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module hilo_muldiv (
  input logic         clk,
  input logic         reset,
  hilo_muldiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        w_accept;
  logic        w_step;
  logic        w_commit;

  logic [4:0]  r_cnt;
  logic        r_isDiv;
  logic        r_divZero;
  logic        r_negRes;
  logic        r_negRem;
  logic [63:0] r_acc;
  logic [31:0] r_opnd;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;
  logic        r_dbz;

  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic [32:0] w_mulSum;
  logic [32:0] w_divShift;
  logic [32:0] w_divDiff;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_absA = (!bus.Unsigned && bus.op_a[31]) ? (~bus.op_a + 32'd1) : bus.op_a;
  assign w_absB = (!bus.Unsigned && bus.op_b[31]) ? (~bus.op_b + 32'd1) : bus.op_b;

  // r_acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
  assign w_mulSum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_divShift = {r_acc[63:32], r_acc[31]};
  assign w_divDiff  = w_divShift - {1'b0, r_opnd};

  assign w_prod = r_negRes ? (~r_acc + 64'd1) : r_acc;
  assign w_quo  = r_negRes ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
  assign w_rem  = r_negRem ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start && (bus.Mul ^ bus.Div)) begin
          w_accept    = 1'b1;
          w_nextState = CALC;
`ifdef HILO_FAST_MUL_EN
          if (bus.Mul) w_nextState = SIGN;
`endif
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (r_cnt == 5'd31) w_nextState = SIGN;
      end
      SIGN: begin
        w_commit    = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= 5'd0;
      r_isDiv   <= 1'b0;
      r_divZero <= 1'b0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_acc     <= 64'd0;
      r_opnd    <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_done <= w_commit;
      r_dbz  <= w_commit & r_isDiv & r_divZero;
      if (w_accept) begin
        r_isDiv   <= bus.Div;
        r_divZero <= (bus.op_b == 32'd0);
        r_negRes  <= !bus.Unsigned && (bus.op_a[31] ^ bus.op_b[31]);
        r_negRem  <= !bus.Unsigned && bus.op_a[31];
        r_cnt     <= 5'd0;
        if (bus.Div) begin
          r_acc  <= {32'd0, w_absA};
          r_opnd <= w_absB;
        end else begin
`ifdef HILO_FAST_MUL_EN
          r_acc  <= {32'd0, w_absA} * {32'd0, w_absB};
`else
          r_acc  <= {32'd0, w_absB};
`endif
          r_opnd <= w_absA;
        end
      end
      if (w_step) begin
        r_cnt <= r_cnt + 5'd1;
        if (r_isDiv) begin
          if (!w_divDiff[32]) r_acc <= {w_divDiff[31:0], r_acc[30:0], 1'b1};
          else                r_acc <= {w_divShift[31:0], r_acc[30:0], 1'b0};
        end else begin
          r_acc <= {w_mulSum, r_acc[31:1]};
        end
      end
      // MTHI/MTLO land in IDLE; a start on the same edge overwrites them at commit
      if (r_state == IDLE) begin
        if (bus.WriteHi) r_hi <= bus.write_data;
        if (bus.WriteLo) r_lo <= bus.write_data;
      end
      if (w_commit) begin
        if (!r_isDiv) begin
          r_hi <= w_prod[63:32];
          r_lo <= w_prod[31:0];
        end else if (!r_divZero) begin
          r_hi <= w_rem;
          r_lo <= w_quo;
        end
      end
    end
  end

  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: arithmetic reference model checked every cycle plus directed literal checks.
// Honours HILO_FAST_MUL_EN for expected multiply latency.
module tb_hilo_muldiv;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hilo_muldiv_if bus();

  hilo_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;
  bit checkEn = 1'b0;

`ifdef HILO_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif
  localparam int DivLat = 33;

  // Reference model state
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;
  int          mPend = 0;
  logic        mDone = 1'b0;
  logic        mDbz = 1'b0;
  logic        pendDbz = 1'b0;
  logic [63:0] pendRes = 64'd0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] refResult(input logic mul, input logic uns,
                                            input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    logic [31:0] uq, ur;
    if (mul) begin
      if (uns) p = {32'd0, a} * {32'd0, b};
      else begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
      end
      return p;
    end
    if (b == 32'd0) return 64'd0;
    if (uns) begin
      uq = a / b;
      ur = a % b;
      return {ur, uq};
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Model: a result lands a fixed number of edges after acceptance; HI/LO writes only when idle
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mHi = 32'd0; mLo = 32'd0; mPend = 0; mDone = 1'b0; mDbz = 1'b0;
    end else begin
      mDone = 1'b0;
      mDbz  = 1'b0;
      if (mPend > 0) begin
        mPend--;
        if (mPend == 0) begin
          if (!pendDbz) begin
            mHi = pendRes[63:32];
            mLo = pendRes[31:0];
          end
          mDone = 1'b1;
          mDbz  = pendDbz;
        end
      end else begin
        if (bus.WriteHi) mHi = bus.write_data;
        if (bus.WriteLo) mLo = bus.write_data;
        if (bus.start && (bus.Mul != bus.Div)) begin
          pendRes = refResult(bus.Mul, bus.Unsigned, bus.op_a, bus.op_b);
          pendDbz = bus.Div && (bus.op_b == 32'd0);
          mPend   = bus.Mul ? MulLat : DivLat;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("hi", bus.hi, mHi);
      checkOutput("lo", bus.lo, mLo);
      checkOutput("busy", {31'd0, bus.busy}, {31'd0, (mPend > 0)});
      checkOutput("done", {31'd0, bus.done}, {31'd0, mDone});
      checkOutput("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, mDbz});
    end
  end

  task automatic clearInputs();
    bus.start = 1'b0; bus.Mul = 1'b0; bus.Div = 1'b0; bus.Unsigned = 1'b0;
    bus.op_a = 32'd0; bus.op_b = 32'd0;
    bus.WriteHi = 1'b0; bus.WriteLo = 1'b0; bus.write_data = 32'd0;
  endtask

  // Launches one operation; edges = edge index at which done was observed
  task automatic applyStimulus(input logic mul, input logic div, input logic uns,
                               input logic [31:0] a, input logic [31:0] b,
                               input int injectAt, output int edges, output int busyCnt);
    @(negedge clk);
    bus.Mul = mul; bus.Div = div; bus.Unsigned = uns;
    bus.op_a = a; bus.op_b = b; bus.start = 1'b1;
    @(negedge clk);
    clearInputs();
    edges   = 0;
    busyCnt = bus.busy ? 1 : 0;
    while (!bus.done && edges < 60) begin
      if (edges == injectAt - 1) begin
        bus.start = 1'b1; bus.Mul = 1'b1; bus.Unsigned = 1'b1;
        bus.op_a = 32'd50; bus.op_b = 32'd3;
      end else begin
        clearInputs();
      end
      @(negedge clk);
      edges++;
      if (bus.busy) busyCnt++;
    end
    clearInputs();
    if (!bus.done) checkOutput("done_timeout", {31'd0, bus.done}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int edges, busyCnt;
    clearInputs();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 checkEn = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_hi", bus.hi, 32'h0);
    checkOutput("rst_lo", bus.lo, 32'h0);
    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
    #2 reset = 1'b1;

    $display("[TB] unsigned multiply");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, edges, busyCnt);
    checkOutput("mulu_edge", edges, MulLat);
    checkOutput("mulu_hi", bus.hi, 32'hFFFFFFFE);
    checkOutput("mulu_lo", bus.lo, 32'h00000001);
    @(negedge clk);
    checkOutput("mulu_done_pulse", {31'd0, bus.done}, 32'd0);

    $display("[TB] signed multiply");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hFFFFFFFD, 32'h00000005, -1, edges, busyCnt);
    checkOutput("muls_hi", bus.hi, 32'hFFFFFFFF);
    checkOutput("muls_lo", bus.lo, 32'hFFFFFFF1);

    $display("[TB] signed divide");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, -1, edges, busyCnt);
    checkOutput("divs_edge", edges, DivLat);
    checkOutput("divs_busy_cycles", busyCnt, 33);
    checkOutput("divs_lo", bus.lo, 32'hFFFFFFFD);
    checkOutput("divs_hi", bus.hi, 32'hFFFFFFFF);

    $display("[TB] invalid starts");
    @(negedge clk);
    bus.start = 1'b1; bus.Mul = 1'b1; bus.Div = 1'b1;
    @(negedge clk);
    bus.Mul = 1'b0; bus.Div = 1'b0;
    @(negedge clk);
    clearInputs();
    checkOutput("invalid_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    checkOutput("invalid_done", {31'd0, bus.done}, 32'd0);

    $display("[TB] MTHI/MTLO then divide by zero");
    @(negedge clk);
    bus.WriteHi = 1'b1; bus.write_data = 32'h11111111;
    @(negedge clk);
    bus.WriteHi = 1'b0; bus.WriteLo = 1'b1; bus.write_data = 32'h22222222;
    @(negedge clk);
    clearInputs();
    checkOutput("mthi", bus.hi, 32'h11111111);
    checkOutput("mtlo", bus.lo, 32'h22222222);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd100, 32'd0, -1, edges, busyCnt);
    checkOutput("dbz_edge", edges, DivLat);
    checkOutput("dbz_flag", {31'd0, bus.div_by_zero}, 32'd1);
    checkOutput("dbz_hi", bus.hi, 32'h11111111);
    checkOutput("dbz_lo", bus.lo, 32'h22222222);
    @(negedge clk);
    checkOutput("dbz_flag_pulse", {31'd0, bus.div_by_zero}, 32'd0);

    $display("[TB] start while busy");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd100, 32'd7, 10, edges, busyCnt);
    checkOutput("busy_start_edge", edges, DivLat);
    checkOutput("busy_start_lo", bus.lo, 32'd14);
    checkOutput("busy_start_hi", bus.hi, 32'd2);
    repeat (2) @(negedge clk);
    checkOutput("busy_start_idle", {31'd0, bus.busy}, 32'd0);

    $display("[TB] signed overflow divide");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, -1, edges, busyCnt);
    checkOutput("ovf_lo", bus.lo, 32'h80000000);
    checkOutput("ovf_hi", bus.hi, 32'h00000000);

    $display("[TB] reset mid-multiply");
    @(negedge clk);
    bus.start = 1'b1; bus.Mul = 1'b1; bus.Unsigned = 1'b1;
    bus.op_a = 32'd1234; bus.op_b = 32'd5678;
    @(negedge clk);
    clearInputs();
    repeat (14) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_hi", bus.hi, 32'h0);
    checkOutput("rst_mid_lo", bus.lo, 32'h0);
    checkOutput("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_mid_done", {31'd0, bus.done}, 32'd0);
    #2 reset = 1'b1;
    repeat (20) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd9, 32'd3, -1, edges, busyCnt);
    checkOutput("post_rst_lo", bus.lo, 32'd3);
    checkOutput("post_rst_hi", bus.hi, 32'd0);

    repeat (3) @(negedge clk);
    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
